card_color_generator: RTL
=========================

# card_color_generator

Responder for the game controller's colour-computation handshake. On a `compute_colors` request it fills a card colour table with `NUM_CARDS/2` colour pairs and shuffles the table in place (Fisher-Yates, LFSR-driven). When the shuffle is complete it raises `computing_colors_finished`. The card-drawing logic then reads the finished table through a registered read port.

## Interface
- `NUM_CARDS`, 16: number of cards; even, 4..64.
- `COLOR_W`, 4: colour code width; must satisfy 2^COLOR_W ≥ NUM_CARDS/2.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `IDX_W` (derived localparam): clog2(NUM_CARDS).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `compute_colors`  in  1  level request from the game controller; held high while that controller is in its colour-computing state.
- `computing_colors_finished`  out  1  registered done flag.
- `colors_valid`  out  1  table holds a complete shuffled result.
- `card_index`  in  IDX_W  read address.
- `card_color`  out  COLOR_W  registered colour of `card_index`.

## Operation

**LFSR**
- 16-bit Fibonacci LFSR, shifting left: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Advances every cycle in every state; reset loads SEED.
- Because it free-runs, the time at which the player presses start selects the shuffle.

**Table**
- NUM_CARDS × COLOR_W register array.
- Reset value is 0 in every entry.

**States**
- IDLE
  - If compute_colors=1: go to FILL, set fill index i=0, clear colors_valid.
- FILL
  - Each cycle: table[i] <= i>>1 (truncated to COLOR_W), then i++.
  - After writing i=NUM_CARDS-1: go to SHUFFLE with i=NUM_CARDS-1.
- SHUFFLE
  - Each cycle: j = lfsr[IDX_W-1:0].
  - If j ≤ i: swap table[i] and table[j] in one cycle, then i--. j=i is a legal no-op swap.
  - If j > i: reject. No write, i unchanged, retry next cycle.
  - After the swap at i=1: go to DONE.
- DONE
  - computing_colors_finished=1 and colors_valid=1.
  - Stay while compute_colors=1.
  - When compute_colors=0 is sampled: go to IDLE and clear computing_colors_finished. colors_valid stays 1.
- The 2-bit state encoding has no spare codes; every value is a valid state.

**Request rules**
- compute_colors falling during FILL or SHUFFLE is ignored; the run completes.
- On reaching DONE with compute_colors already 0, computing_colors_finished is high for exactly one cycle.
- Back-to-back requests: a new run starts only from IDLE. The request must be seen low in DONE first, so the controller's trailing extra-cycle assertion of compute_colors never retriggers a run.

**Read port**
- card_color <= (card_index < NUM_CARDS) ? table[card_index] : 0, every cycle, in every state.
- During FILL and SHUFFLE the read returns intermediate contents; consumers gate on colors_valid.

**Result invariant**
- At DONE, each colour 0..NUM_CARDS/2-1 appears exactly twice, and no other value appears.

## Timing
- Reset values: computing_colors_finished=0, colors_valid=0, card_color=0, state=IDLE, table all 0, lfsr=SEED.
- Reset mid-FILL or mid-SHUFFLE aborts the run and restores all reset values on the next edge.
- Latency: the edge that samples compute_colors=1 in IDLE is E0.
  - FILL occupies edges E1..E_N.
  - SHUFFLE occupies at least NUM_CARDS-1 edges, plus one per rejection.
  - computing_colors_finished is first high after edge E(2·NUM_CARDS-1)+R, where R is the number of rejections.
- computing_colors_finished falls one cycle after compute_colors is sampled low in DONE.
- colors_valid falls on E1 of a new run. It rises together with computing_colors_finished.
- Read latency: 1 cycle from card_index to card_color.

## Test plan
1. Reset check: after rst with NUM_CARDS=16, verify computing_colors_finished=0, colors_valid=0, card_color=0 for indices 0..15, and card_index=15 returns 0.
2. Basic run: raise compute_colors and hold it until finished, then 1 more cycle, then drop it.
   - Finished asserts no earlier than 31 cycles after the sampling edge.
   - Colour histogram over indices 0..15 is exactly two of each of 0..7.
   - Finished falls 1 cycle after compute_colors=0 is sampled.
   - No second run starts.
3. Early drop: pulse compute_colors for 1 cycle. Run completes, and finished is high for exactly 1 cycle.
4. Reset mid-shuffle: assert rst 20 cycles after the request. All outputs return to reset values, and a subsequent request produces a valid permutation.
5. Determinism: two runs with identical rst-to-request delays give identical tables. Runs with request delays of 3, 4 and 5 cycles each pass the histogram check.
6. NUM_CARDS=6, COLOR_W=2: histogram is two each of 0..2. card_index=6 and card_index=7 read 0.

Source files
------------

// File: rtl/card_color_if.sv
// Colour-computation handshake and table read port between the game controller and the
// card colour generator.
interface card_color_if #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned COLOR_W = 4
);
    logic               compute_colors;
    logic               computing_colors_finished;
    logic               colors_valid;
    logic [IDX_W-1:0]   card_index;
    logic [COLOR_W-1:0] card_color;

    modport master (
        output compute_colors,
        output card_index,
        input  computing_colors_finished,
        input  colors_valid,
        input  card_color
    );

    modport slave (
        input  compute_colors,
        input  card_index,
        output computing_colors_finished,
        output colors_valid,
        output card_color
    );
endinterface

// File: rtl/card_color_generator.sv
// Fills a card colour table with NUM_CARDS/2 colour pairs and Fisher-Yates shuffles it in
// place using a free-running LFSR, then serves the table through a registered read port.
module card_color_generator #(
    parameter int unsigned NUM_CARDS = 16,
    parameter int unsigned COLOR_W   = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    card_color_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CARDS);
    localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NUM_CARDS - 1);
    localparam logic [IDX_W:0]   NumCardsW = (IDX_W + 1)'(NUM_CARDS);

    typedef enum logic [1:0] {StIdle, StFill, StShuffle, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [COLOR_W-1:0] tbl_q [NUM_CARDS];
    logic [COLOR_W-1:0] tbl_d [NUM_CARDS];
    logic               finished_q, finished_d;
    logic               valid_q, valid_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic [IDX_W-1:0]   swap_j;
    logic               accept;

    // Random swap partner; draws above the current index are rejected and retried.
    assign swap_j = lfsr_q[IDX_W-1:0];
    assign accept = (swap_j <= idx_q);

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            lfsr_q     <= SEED;
            tbl_q      <= '{default: '0};
            finished_q <= 1'b0;
            valid_q    <= 1'b0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lfsr_q     <= lfsr_d;
            tbl_q      <= tbl_d;
            finished_q <= finished_d;
            valid_q    <= valid_d;
            color_q    <= color_d;
        end
    end

    // Next-state decode; a new run only starts from idle, so a trailing request in DONE
    // must first be seen low.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.compute_colors) state_d = StFill;
            StFill:    if (idx_q == LastIdx) state_d = StShuffle;
            StShuffle: if (accept && (idx_q == IDX_W'(1))) state_d = StDone;
            StDone:    if (!bus.compute_colors) state_d = StIdle;
        endcase
    end

    // Table fill/shuffle, index counter, LFSR, flags and read port next values.
    always_comb begin
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        valid_d = valid_q;
        unique case (state_q)
            StIdle: idx_d = '0;
            StFill: begin
                tbl_d[idx_q] = COLOR_W'(idx_q >> 1);
                valid_d      = 1'b0;
                // Index stays at the last card, which is where the shuffle starts.
                if (idx_q != LastIdx) idx_d = idx_q + IDX_W'(1);
            end
            StShuffle: begin
                if (accept) begin
                    tbl_d[idx_q]  = tbl_q[swap_j];
                    tbl_d[swap_j] = tbl_q[idx_q];
                    idx_d         = idx_q - IDX_W'(1);
                end
            end
            StDone: ;
        endcase
        if (state_d == StDone) valid_d = 1'b1;
        finished_d = (state_d == StDone);
        color_d    = ({1'b0, bus.card_index} < NumCardsW) ? tbl_q[bus.card_index] : '0;
    end

    assign bus.computing_colors_finished = finished_q;
    assign bus.colors_valid              = valid_q;
    assign bus.card_color                = color_q;
endmodule
